proc_control: RTL and testbench
===============================

Name: proc_control

Overview:
- Control unit for the team's simple 9-bit bus processor.
- Latches an instruction from DIN, then sequences the register file (R0..R7), accumulator A, ALU result register G and the shared bus multiplexer over up to four time steps (T0..T3).
- Drives one-hot register read/write enables using two instances of the existing 3-to-8 decoder, plus the bus-select and ALU controls.
- Sits between the instruction source (DIN/Run) and the datapath.

Parameters:
- DATA_W, 9, width of DIN and of the instruction register; instruction fields occupy DIN[8:0].
- OP_W, 3, opcode width, in IR[8:6]; Rx is IR[5:3], Ry is IR[2:0].

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- DIN  input  DATA_W  instruction/immediate input.
- Run  input  1  start request; sampled only in T0.
- IRin  output  1  IR load strobe (informational; IR is internal).
- Rin  output  [0:7]  one-hot register write enable; bit 0 = R0.
- Rout  output  [0:7]  one-hot register bus-drive select; bit 0 = R0.
- Gout  output  1  G drives the bus.
- DINout  output  1  DIN drives the bus.
- Ain  output  1  load A from the bus.
- Gin  output  1  load G with the ALU result.
- AddSub  output  1  ALU operation: 0 = A + bus, 1 = A - bus.
- Done  output  1  one-cycle pulse in the final step of an instruction.

Behaviour:
- Reset (asynchronous, active-high):
  - state = T0, IR = 0.
  - All outputs 0 while in T0 with Run = 0.
  - Reset asserted mid-instruction aborts it: no Done, no further enables; the FSM resumes in T0 after deassertion.
- State register: 2 bits, states T0, T1, T2, T3. Outputs are combinational, decoded from state, IR and Run (Run is used in T0 only).
- Opcodes:
  - 000 = mv Rx,Ry
  - 001 = mvi Rx,#D
  - 010 = add Rx,Ry
  - 011 = sub Rx,Ry
  - 100..111 = nop.
- T0:
  - Run = 0: all outputs 0; stay in T0.
  - Run = 1: IRin = 1; IR <= DIN[8:0] at the clock edge; go to T1.
- T1:
  - mv: Rout[Ry] = 1, Rin[Rx] = 1, Done = 1; go to T0.
  - mvi: DINout = 1, Rin[Rx] = 1, Done = 1; go to T0. DIN must hold the immediate during this cycle.
  - add/sub: Rout[Rx] = 1, Ain = 1; go to T2.
  - nop: Done = 1, no other enables; go to T0.
- T2 (add/sub only): Rout[Ry] = 1, Gin = 1, AddSub = IR[6]; go to T3.
- T3 (add/sub only): Gout = 1, Rin[Rx] = 1, Done = 1; go to T0.
- Latency, counted in cycles from the edge that samples Run = 1:
  - mv, mvi, nop: Done in the next cycle (2 cycles total).
  - add, sub: Done 3 cycles later (4 cycles total).
- Run is ignored outside T0.
- Back-to-back instructions: Run = 1 in the cycle after Done starts the next instruction. There is no idle cycle beyond T0 itself.
- Bus exclusivity: at most one of {any Rout bit, Gout, DINout} is high in any cycle. Rin and Rout are each zero or one-hot.
- Rx == Ry is legal:
  - mv R3,R3 asserts Rout[3] and Rin[3] together.
  - add R3,R3 doubles R3.
- The decoder enable is driven low whenever the corresponding select is inactive, so no stray one-hot bits appear.
- No unreachable-state lockup: undefined encodings cannot occur with 2 bits and 4 states. The default branch still returns to T0.

Decomposition:
- Shared package:
  - state encodings T0..T3 (2'b00..2'b11);
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - field positions (OP_MSB = 8, RX_LSB = 3, RY_LSB = 0).
- Sub-module: reuse the existing dec3to8 twice:
  - one instance for Rin (W = selected register index, En = write-enable term);
  - one instance for Rout (W = selected register index, En = read-enable term).
- FSM and IR stay in proc_control.

Test Plan:
- Reset then idle: Reset = 1 pulse, Run = 0 for 5 cycles -> all outputs 0, Done never high.
- mvi R2,#5:
  - DIN = 9'b001_010_000, Run = 1, then DIN = 9'd5 -> next cycle DINout = 1, Rin = 8'b00100000, Done = 1.
  - Following cycle: all outputs 0.
- mv R0,R7: DIN = 9'b000_000_111 -> T1: Rout = 8'b00000001, Rin = 8'b10000000, Done = 1.
- sub R1,R4: DIN = 9'b011_001_100 ->
  - T1: Rout = 8'b01000000, Ain = 1.
  - T2: Rout = 8'b00001000, Gin = 1, AddSub = 1.
  - T3: Gout = 1, Rin = 8'b01000000, Done = 1.
- Back-to-back and Run masking:
  - add R1,R2 with Run held high throughout -> Run ignored in T1..T3.
  - A second instruction is latched in the cycle after Done.
  - nop (9'b111_000_000) -> Done in T1 with all enables 0.
- Reset mid-op: assert Reset asynchronously during T2 of add -> outputs 0 immediately; Done not asserted; after release, idle in T0 until Run.

Source files
------------

// File: rtl/proc_control_pkg.sv
// Shared constants for the 9-bit bus processor control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package proc_control_pkg;

   localparam int DATA_W = 9;
   localparam int OP_W   = 3;

   // Instruction field positions within IR
   localparam int OP_MSB = 8;
   localparam int RX_LSB = 3;
   localparam int RY_LSB = 0;

   typedef enum logic [1:0] {
      T0 = 2'b00,
      T1 = 2'b01,
      T2 = 2'b10,
      T3 = 2'b11
   } state_t;

   localparam logic [OP_W-1:0] OP_MV  = 3'b000;
   localparam logic [OP_W-1:0] OP_MVI = 3'b001;
   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB = 3'b011;

   function automatic logic [OP_W-1:0] ir_op(input logic [DATA_W-1:0] ir);
      return ir[OP_MSB -: OP_W];
   endfunction

   function automatic logic [2:0] ir_rx(input logic [DATA_W-1:0] ir);
      return ir[RX_LSB +: 3];
   endfunction

   function automatic logic [2:0] ir_ry(input logic [DATA_W-1:0] ir);
      return ir[RY_LSB +: 3];
   endfunction

endpackage

// File: rtl/proc_control_if.sv
// Bundle between instruction source/datapath and the control unit.
// Latency: n/a (wiring only).
// Backpressure: none; Run is only honoured while the controller sits in T0.
interface proc_control_if;
   import proc_control_pkg::*;

   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic              IRin;
   logic [0:7]        Rin;
   logic [0:7]        Rout;
   logic              Gout;
   logic              DINout;
   logic              Ain;
   logic              Gin;
   logic              AddSub;
   logic              Done;

   // Instruction source / datapath side
   modport master (
      output DIN, Run,
      input  IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done
   );

   // Control unit side
   modport slave (
      input  DIN, Run,
      output IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done
   );

endinterface

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable; Y[0] corresponds to W = 0.
// Latency: combinational.
// Backpressure: n/a.
module dec3to8 (
   input  logic [2:0] W,
   input  logic       En,
   output logic [0:7] Y
);

   // Single hot bit at index W when enabled, all zero otherwise
   always_comb begin
      Y = '0;
      if (En) begin
         Y[W] = 1'b1;
      end
   end

endmodule

// File: rtl/proc_control.sv
// Control FSM for the 9-bit bus processor: latches IR, sequences T0..T3.
// Latency: mv/mvi/nop finish one cycle after Run is sampled, add/sub three.
// Backpressure: none; Run is ignored outside T0, outputs are pure decode.
module proc_control
   import proc_control_pkg::*;
(
   input  logic          Clock,
   input  logic          Reset,
   proc_control_if.slave bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;

   logic [2:0] rin_sel, rout_sel;
   logic       rin_en, rout_en;

   logic [OP_W-1:0] op;
   logic [2:0]      rx, ry;

   assign op = ir_op(ir_q);
   assign rx = ir_rx(ir_q);
   assign ry = ir_ry(ir_q);

   // State and instruction register; reset aborts any instruction in flight
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next-state and control decode; bus drivers are chosen so only one is active per step
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      bus.IRin   = 1'b0;
      bus.Gout   = 1'b0;
      bus.DINout = 1'b0;
      bus.Ain    = 1'b0;
      bus.Gin    = 1'b0;
      bus.AddSub = 1'b0;
      bus.Done   = 1'b0;
      rin_en     = 1'b0;
      rin_sel    = rx;
      rout_en    = 1'b0;
      rout_sel   = ry;

      case (state_q)
         T0: begin
            if (bus.Run) begin
               bus.IRin = 1'b1;
               ir_d     = bus.DIN;
               state_d  = T1;
            end
         end

         T1: begin
            case (op)
               OP_MV: begin
                  rout_en  = 1'b1;
                  rout_sel = ry;
                  rin_en   = 1'b1;
                  bus.Done = 1'b1;
                  state_d  = T0;
               end
               OP_MVI: begin
                  bus.DINout = 1'b1;
                  rin_en     = 1'b1;
                  bus.Done   = 1'b1;
                  state_d    = T0;
               end
               OP_ADD, OP_SUB: begin
                  rout_en  = 1'b1;
                  rout_sel = rx;
                  bus.Ain  = 1'b1;
                  state_d  = T2;
               end
               default: begin
                  bus.Done = 1'b1;
                  state_d  = T0;
               end
            endcase
         end

         T2: begin
            rout_en    = 1'b1;
            rout_sel   = ry;
            bus.Gin    = 1'b1;
            bus.AddSub = ir_q[6];
            state_d    = T3;
         end

         T3: begin
            bus.Gout = 1'b1;
            rin_en   = 1'b1;
            bus.Done = 1'b1;
            state_d  = T0;
         end

         default: begin
            state_d = T0;
         end
      endcase
   end

   dec3to8 u_dec_rin (
      .W  (rin_sel),
      .En (rin_en),
      .Y  (bus.Rin)
   );

   dec3to8 u_dec_rout (
      .W  (rout_sel),
      .En (rout_en),
      .Y  (bus.Rout)
   );

endmodule

// File: tb/tb_proc_control.sv
// Directed self-checking bench for proc_control.
// Inputs change 1 time unit after the rising edge, outputs are sampled on the falling edge.
// Expected output vectors are hand-computed from the instruction semantics.
module tb_proc_control;

   logic Clock;
   logic Reset;

   proc_control_if bus ();

   proc_control dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int n_checks;
   int n_fails;

   // {IRin, Rin[0:7], Rout[0:7], Gout, DINout, Ain, Gin, AddSub, Done}
   logic [22:0] outs;
   assign outs = {bus.IRin, bus.Rin, bus.Rout, bus.Gout, bus.DINout,
                  bus.Ain, bus.Gin, bus.AddSub, bus.Done};

   localparam logic [22:0] IDLE = 23'd0;

   function automatic logic [22:0] ov(input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic gout,
                                      input logic dinout, input logic ain,
                                      input logic gin, input logic addsub,
                                      input logic done);
      return {irin, rin, rout, gout, dinout, ain, gin, addsub, done};
   endfunction

   task automatic check_eq(input string tag, input logic [22:0] got, input logic [22:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Sample on the falling edge, then advance to just after the next rising edge
   task automatic expect_cycle(input string tag, input logic [22:0] exp);
      @(negedge Clock);
      check_eq(tag, outs, exp);
      @(posedge Clock);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      Reset    = 1'b1;
      bus.Run  = 1'b0;
      bus.DIN  = '0;

      // Reset then idle
      @(negedge Clock);
      check_eq("reset_outs", outs, IDLE);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         expect_cycle($sformatf("idle_%0d", i), IDLE);
      end

      // mvi R2,#5
      bus.DIN = 9'b001_010_000;
      bus.Run = 1'b1;
      expect_cycle("mvi_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.DIN = 9'd5;
      bus.Run = 1'b0;
      expect_cycle("mvi_t1", ov(0, 8'b00100000, 8'b0, 0, 1, 0, 0, 0, 1));
      expect_cycle("mvi_after", IDLE);

      // mv R0,R7
      bus.DIN = 9'b000_000_111;
      bus.Run = 1'b1;
      expect_cycle("mv_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.Run = 1'b0;
      expect_cycle("mv_t1", ov(0, 8'b10000000, 8'b00000001, 0, 0, 0, 0, 0, 1));

      // sub R1,R4
      bus.DIN = 9'b011_001_100;
      bus.Run = 1'b1;
      expect_cycle("sub_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.Run = 1'b0;
      bus.DIN = 9'b000_111_111;
      expect_cycle("sub_t1", ov(0, 8'b0, 8'b01000000, 0, 0, 1, 0, 0, 0));
      expect_cycle("sub_t2", ov(0, 8'b0, 8'b00001000, 0, 0, 0, 1, 1, 0));
      expect_cycle("sub_t3", ov(0, 8'b01000000, 8'b0, 1, 0, 0, 0, 0, 1));
      expect_cycle("sub_after", IDLE);

      // mv R3,R3: same register read and written
      bus.DIN = 9'b000_011_011;
      bus.Run = 1'b1;
      expect_cycle("mv33_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.Run = 1'b0;
      expect_cycle("mv33_t1", ov(0, 8'b00010000, 8'b00010000, 0, 0, 0, 0, 0, 1));

      // add R1,R2 with Run held high; DIN changes must not disturb it
      bus.DIN = 9'b010_001_010;
      bus.Run = 1'b1;
      expect_cycle("add_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.DIN = 9'b001_111_000;
      expect_cycle("add_t1", ov(0, 8'b0, 8'b01000000, 0, 0, 1, 0, 0, 0));
      expect_cycle("add_t2", ov(0, 8'b0, 8'b00100000, 0, 0, 0, 1, 0, 0));
      bus.DIN = 9'b111_000_000;
      expect_cycle("add_t3", ov(0, 8'b01000000, 8'b0, 1, 0, 0, 0, 0, 1));
      // Back-to-back: nop latched in the cycle right after Done
      expect_cycle("b2b_nop_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.Run = 1'b0;
      expect_cycle("nop_t1", ov(0, 8'b0, 8'b0, 0, 0, 0, 0, 0, 1));
      expect_cycle("nop_after", IDLE);

      // Reset asserted asynchronously during T2 of add
      bus.DIN = 9'b010_001_010;
      bus.Run = 1'b1;
      expect_cycle("rst_add_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.Run = 1'b0;
      expect_cycle("rst_add_t1", ov(0, 8'b0, 8'b01000000, 0, 0, 1, 0, 0, 0));
      #2;
      Reset = 1'b1;
      #1;
      check_eq("rst_midop_outs", outs, IDLE);
      @(posedge Clock);
      #1;
      check_eq("rst_held_no_done", outs, IDLE);
      #2;
      Reset = 1'b0;
      @(posedge Clock);
      #1;
      expect_cycle("rst_idle_0", IDLE);
      expect_cycle("rst_idle_1", IDLE);

      // Resumes normally from T0
      bus.DIN = 9'b001_101_000;
      bus.Run = 1'b1;
      expect_cycle("resume_t0", ov(1, 8'b0, 8'b0, 0, 0, 0, 0, 0, 0));
      bus.Run = 1'b0;
      bus.DIN = 9'd7;
      expect_cycle("resume_t1", ov(0, 8'b00000100, 8'b0, 0, 1, 0, 0, 0, 1));
      expect_cycle("resume_after", IDLE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
